// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 key tracker
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [3:0] PS2_LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BREAK = 1'b1
  } ps2_state_e;

  // bits holds start, data[7:0], parity (LSB first); stop is checked separately
  function automatic logic ps2_frame_ok(input logic [9:0] bits, input logic stop);
    return (bits[0] == 1'b0) && stop && (^bits[9:1]);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - show-ahead byte FIFO with wrap-bit pointers
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_wr, do_rd;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  // full is taken before any pop in the same cycle, so a pop never makes room for a write
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_rd) rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 receiver, byte buffer and make/break key tracker
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pause,
  output logic [7:0] key_code,
  output logic [7:0] key_count,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          last_edge, frame_pass;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          wr_en, rd_en, empty, full;
  logic [7:0]    rd_data;

  ps2_state_e    state_q, state_d;
  logic [7:0]    key_code_q, key_code_d;
  logic [7:0]    key_count_q, key_count_d;
  logic          key_valid_q, key_valid_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall       = clk_s3_q && !clk_s2_q;
  assign last_edge  = fall && (bit_cnt_q == PS2_LAST_BIT);
  assign frame_pass = ps2_frame_ok(shift_q, dat_s2_q);
  assign wr_en      = last_edge && frame_pass;

  // Bits shift in from the top so that after ten edges shift_q[0] holds the start bit
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    frame_err_d = last_edge && !frame_pass;
    overflow_d  = overflow_q || (wr_en && full);
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == PS2_LAST_BIT) begin
        bit_cnt_d = '0;
      end else begin
        shift_d   = {dat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        to_cnt_d  = '0;
        bit_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .wr_en   (wr_en),
    .wr_data (shift_q[8:1]),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

  assign rd_en = !empty && !pause;

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_count_d = key_count_q;
    key_valid_d = key_valid_q;
    if (rd_en) begin
      unique case (state_q)
        IDLE: begin
          if (rd_data == PS2_BREAK) begin
            state_d = BREAK;
          end else if (rd_data == PS2_EXT) begin
            state_d = IDLE;
          end else if (!(key_valid_q && rd_data == key_code_q)) begin
            key_code_d  = rd_data;
            key_valid_d = 1'b1;
            key_count_d = key_count_q + 8'd1;
          end
        end
        BREAK: begin
          // A release blanks the digits but leaves the last code in place
          if (rd_data == key_code_q) key_valid_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_count_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_count_q <= key_count_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_count = key_count_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

  localparam int TIMEOUT = 5000;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       pause;
  logic [7:0] key_code;
  logic [7:0] key_count;
  logic       key_valid;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  ps2_key_tracker #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .pause     (pause),
    .key_code  (key_code),
    .key_count (key_count),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_parity);
    logic p;
    p = ~^b;
    if (bad_parity) p = ~p;
    return {1'b1, p, b, 1'b0};
  endfunction

  // data changes mid-way through the high phase; returns with ps2_clk just driven low
  task automatic ps2_edge_low(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_edge_low(f[i]);
      ps2_rise();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_parity);
    send_bits(mk_frame(b, bad_parity), 11);
  endtask

  task automatic check_keys(input string tag, input logic [7:0] code, input logic [7:0] cnt,
                            input logic valid);
    check({tag, ".code"}, {24'd0, key_code}, {24'd0, code});
    check({tag, ".count"}, {24'd0, key_count}, {24'd0, cnt});
    check({tag, ".valid"}, {31'd0, key_valid}, {31'd0, valid});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] f;
    int          e0;
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_keys("reset", 8'h00, 8'h00, 1'b0);
    check("reset.err", {31'd0, frame_err}, 32'd0);
    check("reset.ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk) clrn = 1'b1;
    repeat (5) @(negedge clk);

    // first make code, with exact write-to-output latency
    f = mk_frame(8'h1C, 1'b0);
    send_bits(f, 10);
    ps2_edge_low(f[10]);
    repeat (3) @(posedge clk);
    #1 check("lat.before", {31'd0, key_valid}, 32'd0);
    @(posedge clk);
    #1 check_keys("lat.after", 8'h1C, 8'h01, 1'b1);
    ps2_rise();

    for (int i = 0; i < 3; i++) send_byte(8'h1C, 1'b0);
    check_keys("typematic", 8'h1C, 8'h01, 1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_keys("break", 8'h1C, 8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    check_keys("make23", 8'h23, 8'h02, 1'b1);

    // bad parity: one-cycle error pulse, nothing buffered
    e0 = err_pulses;
    f = mk_frame(8'h15, 1'b1);
    send_bits(f, 10);
    ps2_edge_low(f[10]);
    repeat (2) @(posedge clk);
    #1 check("perr.pre", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1 check("perr.pulse", {31'd0, frame_err}, 32'd1);
    @(posedge clk);
    #1 check("perr.post", {31'd0, frame_err}, 32'd0);
    ps2_rise();
    check("perr.count", err_pulses - e0, 32'd1);
    check_keys("perr.keys", 8'h23, 8'h02, 1'b1);
    send_byte(8'h15, 1'b0);
    check_keys("good15", 8'h15, 8'h03, 1'b1);

    // partial frame abandoned by timeout
    e0 = err_pulses;
    send_bits(mk_frame(8'h5A, 1'b0), 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    send_byte(8'h24, 1'b0);
    check_keys("timeout", 8'h24, 8'h04, 1'b1);
    check("timeout.noerr", err_pulses - e0, 32'd0);
    send_byte(8'hE0, 1'b0);
    check_keys("ext", 8'h24, 8'h04, 1'b1);

    // fresh start, then overflow while paused
    @(negedge clk) clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    pause = 1'b1;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    check_keys("paused", 8'h00, 8'h00, 1'b0);
    check("paused.ovf", {31'd0, overflow}, 32'd1);
    @(negedge clk) pause = 1'b0;
    repeat (12) @(negedge clk);
    check_keys("drain", 8'h08, 8'h08, 1'b1);
    check("drain.ovf", {31'd0, overflow}, 32'd1);

    // asynchronous reset in the middle of a frame
    send_bits(mk_frame(8'h33, 1'b0), 5);
    @(posedge clk);
    #3 clrn = 1'b0;
    #1;
    check_keys("areset", 8'h00, 8'h00, 1'b0);
    check("areset.ovf", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    send_byte(8'h1C, 1'b0);
    check_keys("after_reset", 8'h1C, 8'h01, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
